// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for one shared 8-way resource; grant is held while the owner keeps requesting.
// Define ARB_TIMEOUT_EN to preempt an owner that has held for MAX_HOLD cycles while others wait.
module rr_arbiter_8 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       busy
);

  localparam int unsigned N      = 8;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned HOLD_W = 8;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              preempt;
  logic [IDX_W-1:0]  pick_req;
  logic [IDX_W-1:0]  pick_pre;

  // First set bit of vec, searching upward from base+1 and wrapping; base itself is checked last.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [IDX_W-1:0] base,
                                               input logic [N-1:0] vec);
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] cand;
    pick = base;
    for (int k = N; k >= 1; k--) begin
      cand = base + IDX_W'(k);
      if (vec[cand]) pick = cand;
    end
    return pick;
  endfunction

  assign pick_req = rr_pick(gnt_idx, req);

`ifdef ARB_TIMEOUT_EN
  logic [N-1:0] others;
  assign others   = req & ~(N'(1) << gnt_idx);
  assign pick_pre = rr_pick(gnt_idx, others);
  assign preempt  = (hold_q == HOLD_W'(MAX_HOLD)) && ena && (others != '0);
`else
  assign pick_pre = gnt_idx;
  assign preempt  = 1'b0;
`endif

  // Next-state, next grantee and hold counter.
  always_comb begin
    state_d = state_q;
    idx_d   = gnt_idx;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (ena && (req != '0)) begin
          state_d = GRANT;
          idx_d   = pick_req;
          hold_d  = HOLD_W'(1);
        end
      end
      GRANT: begin
        if (req[gnt_idx]) begin
          if (preempt) begin
            idx_d  = pick_pre;
            hold_d = HOLD_W'(1);
          end else if (hold_q != HOLD_W'(MAX_HOLD)) begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end else if (ena && (req != '0)) begin
          idx_d  = pick_req;
          hold_d = HOLD_W'(1);
        end else begin
          state_d = IDLE;
          hold_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        hold_d  = '0;
      end
    endcase
  end

  // State register and registered outputs; gnt is the decoded grant index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      gnt     <= '0;
      gnt_idx <= IDX_W'(7);
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      gnt_idx <= idx_d;
      busy    <= (state_d == GRANT);
      gnt     <= (state_d == GRANT) ? (N'(1) << idx_d) : '0;
    end
  end

endmodule

// File: doc/rr_arbiter_8.md
Name: rr_arbiter_8

Overview:
- Round-robin arbiter that shares one 8-way resource (e.g. one Game of Life row-update port) among 8 requesters.
- Computes a 3-bit grant index and drives a one-hot grant through the team's 3-to-8 decoding scheme.
- Holds the grant while the owner keeps requesting.
- Sits between the cell-row workers and the shared grid memory write port.

Parameters:
- MAX_HOLD, 16: maximum consecutive cycles one owner may hold the grant while others wait. Used only with ARB_TIMEOUT_EN. Legal range 2..255.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- ena  input  1  arbitration enable; when low, no new grant is issued.
- req  input  8  request vector; bit i high means requester i wants or holds the resource.
- gnt  output  8  one-hot grant. All-zero when idle. Registered.
- gnt_idx  output  3  binary index of the current or last grantee. Registered.
- busy  output  1  high while a grant is active. Equals the OR of the gnt bits.

Behaviour:
- Reset (rst_n low at a clk edge):
  - gnt=8'h00, gnt_idx=3'd7, busy=0, state=IDLE, hold counter=0.
  - gnt_idx=7 means requester 0 has first priority after reset.
- Priority order: search starts at (gnt_idx+1) mod 8, ascending, wrapping 7->0. The first set bit of the eligible request vector wins.
- States: IDLE and GRANT.
- IDLE:
  - If ena=1 and req!=0, the next edge moves to GRANT: gnt_idx=winner, gnt=one-hot(winner), busy=1, hold counter=1.
  - Latency is 1 cycle from req sampled to gnt visible.
  - Otherwise the block stays in IDLE with gnt=0; gnt_idx keeps the last grantee.
- GRANT, owner still requesting (req[gnt_idx]=1): grant is held and the hold counter increments, saturating at MAX_HOLD.
- GRANT, owner releases (req[gnt_idx]=0):
  - If ena=1 and another request is pending: direct handoff on the next edge to the winner searched from gnt_idx+1. No idle gap; hold counter=1.
  - Otherwise: next edge goes to IDLE with gnt=0, busy=0; gnt_idx is unchanged.
- ena=0 during GRANT does not revoke the current grant. The owner keeps it until release, then the block goes to IDLE.
- gnt is always zero or exactly one-hot, and gnt[gnt_idx]=busy.
- An owner releasing and re-raising req in the same cycle is not distinguishable from holding; it is treated as a hold.
- Requests arriving in the same cycle as a release are eligible for that handoff.
- Reset asserted mid-grant forces the reset values on that edge regardless of req or ena.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - In GRANT, if the hold counter equals MAX_HOLD, the owner still requests, and any other req bit is set with ena=1, the owner is preempted on the next edge.
  - The grant moves to the next requester in round-robin order, excluding the current owner; hold counter=1.
  - If no other request is pending, the owner keeps the grant and the counter stays at MAX_HOLD.
- Undefined: no preemption. The owner holds indefinitely, and the hold counter logic may be omitted.

Test Plan:
- Reset with req=8'hFF, ena=1, then release rst_n -> 1 cycle later gnt=8'h01, gnt_idx=0, busy=1.
- req=8'h05, owner 0 drops req[0] at cycle 5 -> next edge gnt=8'h04, gnt_idx=2, with no cycle where gnt=0.
- Owner 2 granted with req=8'h04 only; drop req[2] -> next edge gnt=8'h00, busy=0, gnt_idx stays 2. Then req=8'h05 -> gnt=8'h01 (search starts at index 3 and wraps to 0).
- ena=0 while owner 3 is granted and req=8'h18 -> grant to 3 is held. When req[3] drops -> IDLE, gnt=0. Raise ena -> 1 cycle later gnt=8'h10.
- ARB_TIMEOUT_EN, MAX_HOLD=4, req=8'h03 held constant -> gnt alternates 8'h01 and 8'h02 every 4 cycles. With req=8'h01 only, gnt=8'h01 is held indefinitely.
- rst_n low for one edge while gnt=8'h20 -> next cycle gnt=0, gnt_idx=7, busy=0. Then req=8'hA0 -> gnt=8'h20.
